// File: rtl/pll_dyn_pkg.sv
// Shared types and constants for the PLL dynamic-reconfiguration controller.
package pll_dyn_pkg;

  localparam int unsigned ICP_W = 6;
  localparam int unsigned RES_W = 3;
  localparam int unsigned CAP_W = 2;

  localparam logic [ICP_W-1:0] DEF_ICP = 6'h08;
  localparam logic [RES_W-1:0] DEF_RES = 3'd4;
  localparam logic [CAP_W-1:0] DEF_CAP = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_LOCKED,
    ST_FAIL
  } state_e;

endpackage

// File: rtl/pll_dyn_ctrl_sync_2ff.sv
// Two-flop synchronizer bringing the raw PLL lock into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_dyn_ctrl.sv
// PLL reset/relock sequencer with registered ICP/LPF settings and retry limit.
// Define PLL_DYN_CTRL_AUTO_RELOCK_EN to relock automatically on loss of lock instead of failing.
module pll_dyn_ctrl
  import pll_dyn_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned MAX_RETRY    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ICP_W-1:0] icp_req,
  input  logic [RES_W-1:0] lpfres_req,
  input  logic [CAP_W-1:0] lpfcap_req,
  input  logic             pll_lock,
  output logic             pll_reset,
  output logic [ICP_W-1:0] icpsel,
  output logic [RES_W-1:0] lpfres,
  output logic [CAP_W-1:0] lpfcap,
  output logic             busy,
  output logic             locked,
  output logic             fail,
  output logic [3:0]       attempts
);

  localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned STB_W = $clog2(LOCK_STABLE + 1);

  localparam logic [RST_W-1:0] RST_LAST   = RST_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST   = STB_W'(LOCK_STABLE - 1);
  localparam logic [3:0]       RETRY_LAST = 4'(MAX_RETRY - 1);

  state_e           state_q, state_d;
  logic             pll_reset_q, pll_reset_d;
  logic [ICP_W-1:0] icpsel_q, icpsel_d;
  logic [RES_W-1:0] lpfres_q, lpfres_d;
  logic [CAP_W-1:0] lpfcap_q, lpfcap_d;
  logic             busy_q, busy_d;
  logic             locked_q, locked_d;
  logic             fail_q, fail_d;
  logic [3:0]       attempts_q, attempts_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [STB_W-1:0] stab_cnt_q, stab_cnt_d;

  logic             lock_s;
  logic             start_ok;
  logic             timeout;
  logic [TO_W-1:0]  to_inc;
  logic [STB_W-1:0] stab_inc;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign start_ok = start && (state_q inside {ST_IDLE, ST_LOCKED, ST_FAIL});
  assign timeout  = (to_cnt_q == TO_LAST);
  // Timeout counter saturates so a late lock drop in STABLE times out at once.
  assign to_inc   = timeout ? to_cnt_q : to_cnt_q + TO_W'(1);
  // The WAIT_LOCK sample counts as the first consecutive lock cycle.
  assign stab_inc = stab_cnt_q + STB_W'(1);

  always_comb begin
    state_d     = state_q;
    pll_reset_d = pll_reset_q;
    icpsel_d    = icpsel_q;
    lpfres_d    = lpfres_q;
    lpfcap_d    = lpfcap_q;
    busy_d      = busy_q;
    locked_d    = locked_q;
    fail_d      = fail_q;
    attempts_d  = attempts_q;
    rst_cnt_d   = rst_cnt_q;
    to_cnt_d    = to_cnt_q;
    stab_cnt_d  = stab_cnt_q;

    if (start_ok) begin
      icpsel_d    = icp_req;
      lpfres_d    = lpfres_req;
      lpfcap_d    = lpfcap_req;
      attempts_d  = '0;
      locked_d    = 1'b0;
      fail_d      = 1'b0;
      busy_d      = 1'b1;
      state_d     = ST_RESET;
      pll_reset_d = 1'b1;
      rst_cnt_d   = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (rst_cnt_q == RST_LAST) begin
            state_d     = ST_WAIT_LOCK;
            pll_reset_d = 1'b0;
            to_cnt_d    = '0;
            stab_cnt_d  = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + RST_W'(1);
          end
        end
        ST_WAIT_LOCK, ST_STABLE: begin
          to_cnt_d = to_inc;
          if (lock_s) begin
            if (state_q == ST_WAIT_LOCK) begin
              state_d    = ST_STABLE;
              stab_cnt_d = '0;
            end else if (stab_inc == STB_LAST) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
              busy_d   = 1'b0;
            end else begin
              stab_cnt_d = stab_inc;
            end
          end else if (timeout) begin
            pll_reset_d = 1'b1;
            if (attempts_q == RETRY_LAST) begin
              state_d = ST_FAIL;
              fail_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              if (attempts_q != 4'hF) begin
                attempts_d = attempts_q + 4'd1;
              end
              state_d   = ST_RESET;
              rst_cnt_d = '0;
            end
          end else begin
            state_d    = ST_WAIT_LOCK;
            stab_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          if (!lock_s) begin
            locked_d    = 1'b0;
            pll_reset_d = 1'b1;
`ifdef PLL_DYN_CTRL_AUTO_RELOCK_EN
            busy_d     = 1'b1;
            attempts_d = '0;
            state_d    = ST_RESET;
            rst_cnt_d  = '0;
`else
            fail_d  = 1'b1;
            state_d = ST_FAIL;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pll_reset_q <= 1'b1;
      icpsel_q    <= DEF_ICP;
      lpfres_q    <= DEF_RES;
      lpfcap_q    <= DEF_CAP;
      busy_q      <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      attempts_q  <= '0;
      rst_cnt_q   <= '0;
      to_cnt_q    <= '0;
      stab_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pll_reset_q <= pll_reset_d;
      icpsel_q    <= icpsel_d;
      lpfres_q    <= lpfres_d;
      lpfcap_q    <= lpfcap_d;
      busy_q      <= busy_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
      attempts_q  <= attempts_d;
      rst_cnt_q   <= rst_cnt_d;
      to_cnt_q    <= to_cnt_d;
      stab_cnt_q  <= stab_cnt_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign icpsel    = icpsel_q;
  assign lpfres    = lpfres_q;
  assign lpfcap    = lpfcap_q;
  assign busy      = busy_q;
  assign locked    = locked_q;
  assign fail      = fail_q;
  assign attempts  = attempts_q;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Self-checking bench for pll_dyn_ctrl: cycle model compared every negedge plus directed literal checks.
module tb_pll_dyn_ctrl;
  import pll_dyn_pkg::*;

  localparam int RST_CYCLES   = 4;
  localparam int LOCK_TIMEOUT = 100;
  localparam int LOCK_STABLE  = 8;
  localparam int MAX_RETRY    = 3;

  logic       clk, rst_n, start, pll_lock;
  logic [5:0] icp_req;
  logic [2:0] lpfres_req;
  logic [1:0] lpfcap_req;
  logic       pll_reset, busy, locked, fail;
  logic [5:0] icpsel;
  logic [2:0] lpfres;
  logic [1:0] lpfcap;
  logic [3:0] attempts;

  int n_checks = 0;
  int n_errors = 0;

  pll_dyn_ctrl #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .LOCK_STABLE  (LOCK_STABLE),
    .MAX_RETRY    (MAX_RETRY)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .icp_req    (icp_req),
    .lpfres_req (lpfres_req),
    .lpfcap_req (lpfcap_req),
    .pll_lock   (pll_lock),
    .pll_reset  (pll_reset),
    .icpsel     (icpsel),
    .lpfres     (lpfres),
    .lpfcap     (lpfcap),
    .busy       (busy),
    .locked     (locked),
    .fail       (fail),
    .attempts   (attempts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: phase + down-counter for the reset pulse, elapsed
  // cycles since the pulse ended, and length of the current lock run.
  localparam int M_IDLE = 0, M_RESET = 1, M_WAIT = 2, M_STABLE = 3, M_LOCKED = 4, M_FAIL = 5;
  int         m_mode, m_rst_left, m_elapsed, m_run;
  logic [1:0] m_sync;
  logic       m_lk, m_pll_reset, m_busy, m_locked, m_fail;
  logic [5:0] m_icp;
  logic [2:0] m_res;
  logic [1:0] m_cap;
  logic [3:0] m_att;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_pll_reset = 1'b1; m_icp = DEF_ICP; m_res = DEF_RES; m_cap = DEF_CAP;
      m_busy = 1'b0; m_locked = 1'b0; m_fail = 1'b0; m_att = 4'd0; m_sync = 2'b00;
      m_rst_left = 0; m_elapsed = 0; m_run = 0;
    end else begin
      m_lk   = m_sync[1];
      m_sync = {m_sync[0], pll_lock};
      if (start && (m_mode == M_IDLE || m_mode == M_LOCKED || m_mode == M_FAIL)) begin
        m_icp = icp_req; m_res = lpfres_req; m_cap = lpfcap_req;
        m_att = 4'd0; m_locked = 1'b0; m_fail = 1'b0; m_busy = 1'b1;
        m_mode = M_RESET; m_rst_left = RST_CYCLES; m_pll_reset = 1'b1;
      end else begin
        case (m_mode)
          M_RESET: begin
            m_rst_left--;
            if (m_rst_left == 0) begin
              m_mode = M_WAIT; m_pll_reset = 1'b0; m_elapsed = 0;
            end
          end
          M_WAIT, M_STABLE: begin
            if (m_lk) begin
              m_run = (m_mode == M_WAIT) ? 1 : m_run + 1;
              m_elapsed++;
              if (m_run >= LOCK_STABLE) begin
                m_mode = M_LOCKED; m_locked = 1'b1; m_busy = 1'b0;
              end else begin
                m_mode = M_STABLE;
              end
            end else if (m_elapsed >= LOCK_TIMEOUT - 1) begin
              m_pll_reset = 1'b1;
              if (m_att == 4'(MAX_RETRY - 1)) begin
                m_mode = M_FAIL; m_fail = 1'b1; m_busy = 1'b0;
              end else begin
                if (m_att < 4'd15) m_att = m_att + 4'd1;
                m_mode = M_RESET; m_rst_left = RST_CYCLES;
              end
            end else begin
              m_elapsed++;
              m_mode = M_WAIT;
            end
          end
          M_LOCKED: begin
            if (!m_lk) begin
              m_locked = 1'b0; m_pll_reset = 1'b1;
`ifdef PLL_DYN_CTRL_AUTO_RELOCK_EN
              m_busy = 1'b1; m_att = 4'd0; m_mode = M_RESET; m_rst_left = RST_CYCLES;
`else
              m_fail = 1'b1; m_mode = M_FAIL;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance n cycles; at each negedge compare all outputs with the model.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("model_outputs",
            {13'b0, pll_reset, icpsel, lpfres, lpfcap, busy, locked, fail, attempts},
            {13'b0, m_pll_reset, m_icp, m_res, m_cap, m_busy, m_locked, m_fail, m_att});
    end
  endtask

  task automatic kick(input logic [5:0] icp, input logic [2:0] res, input logic [1:0] cap);
    icp_req = icp; lpfres_req = res; lpfcap_req = cap;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  int n_high;
  int n_falls;
  logic prev_rst;

  initial begin
    rst_n = 1'b0; start = 1'b0; pll_lock = 1'b0;
    icp_req = '0; lpfres_req = '0; lpfcap_req = '0;

    // Reset values
    step(3);
    check("rst_pll_reset", pll_reset, 1);
    check("rst_icpsel", icpsel, DEF_ICP);
    check("rst_lpfres", lpfres, DEF_RES);
    check("rst_lpfcap", lpfcap, DEF_CAP);
    check("rst_busy", busy, 0);
    check("rst_attempts", attempts, 0);
    rst_n = 1'b1;
    step(5);
    check("idle_pll_reset", pll_reset, 1);

    // Nominal lock, with an ignored start while in WAIT_LOCK
    kick(6'h15, 3'd3, 2'd1);
    check("nom_icpsel", icpsel, 6'h15);
    check("nom_busy", busy, 1);
    n_high = 1;
    while (pll_reset && n_high < 40) begin
      step(1);
      if (pll_reset) n_high++;
    end
    check("nom_rst_pulse_len", n_high, RST_CYCLES);
    step(5);
    icp_req = 6'h3F; start = 1'b1;
    step(1);
    start = 1'b0;
    check("busy_start_icpsel", icpsel, 6'h15);
    check("busy_start_pll_reset", pll_reset, 0);
    step(14);
    pll_lock = 1'b1;
    step(9);
    check("nom_locked_early", locked, 0);
    step(1);
    check("nom_locked", locked, 1);
    check("nom_attempts", attempts, 0);
    check("nom_busy_done", busy, 0);

    // Lock drop while LOCKED
    pll_lock = 1'b0;
    step(2);
    check("drop_locked_held", locked, 1);
    step(1);
    check("drop_locked_clear", locked, 0);
    check("drop_pll_reset", pll_reset, 1);
`ifdef PLL_DYN_CTRL_AUTO_RELOCK_EN
    check("drop_relock_busy", busy, 1);
    check("drop_relock_fail", fail, 0);
`else
    check("drop_fail", fail, 1);
    check("drop_busy", busy, 0);
`endif
    pll_lock = 1'b1;
    step(30);

    // Retry then success
    rst_n = 1'b0; pll_lock = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    kick(6'h2A, 3'd5, 2'd2);
    step(103);
    check("retry_before_timeout", pll_reset, 0);
    step(1);
    check("retry_second_pulse", pll_reset, 1);
    check("retry_attempts", attempts, 1);
    step(4);
    check("retry_pulse_end", pll_reset, 0);
    pll_lock = 1'b1;
    step(10);
    check("retry_locked", locked, 1);
    check("retry_attempts_final", attempts, 1);

    // Exhaustion
    pll_lock = 1'b0;
    kick(6'h07, 3'd1, 2'd3);
    n_falls = 0;
    prev_rst = pll_reset;
    for (int i = 0; i < 311; i++) begin
      step(1);
      if (prev_rst && !pll_reset) n_falls++;
      prev_rst = pll_reset;
    end
    check("exh_reset_pulses", n_falls, 3);
    check("exh_fail_early", fail, 0);
    step(1);
    check("exh_fail", fail, 1);
    check("exh_pll_reset", pll_reset, 1);
    check("exh_attempts", attempts, 2);
    check("exh_busy", busy, 0);

    // Lock glitch restarts the stable count
    kick(6'h15, 3'd3, 2'd1);
    step(4);
    check("gl_pulse_end", pll_reset, 0);
    step(3);
    pll_lock = 1'b1;
    step(5);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(4);
    check("gl_no_early_lock", locked, 0);
    step(5);
    check("gl_locked_late", locked, 0);
    step(1);
    check("gl_locked", locked, 1);

    // Synchronous reset during WAIT_LOCK
    pll_lock = 1'b0;
    kick(6'h3F, 3'd7, 2'd3);
    step(10);
    check("ar_in_wait", pll_reset, 0);
    rst_n = 1'b0;
    step(1);
    check("ar_pll_reset", pll_reset, 1);
    check("ar_icpsel", icpsel, DEF_ICP);
    check("ar_lpfres", lpfres, DEF_RES);
    check("ar_lpfcap", lpfcap, DEF_CAP);
    check("ar_flags", {busy, locked, fail}, 3'b000);
    check("ar_attempts", attempts, 0);
    rst_n = 1'b1;
    step(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pll_dyn_ctrl.md
PLL_DYN_CTRL -- requirements
Module: pll_dyn_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: PLL reset pulse length in clk cycles (>=2).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: maximum cycles to wait for lock per attempt.
REQ-003 SHALL have parameter LOCK_STABLE, default 256: consecutive synchronized-lock cycles required before reporting locked.
REQ-004 SHALL have parameter MAX_RETRY, default 4: attempts before fail (>=1).
REQ-005 SHALL have port clk, input, 1: the single clock, same 50 MHz reference that feeds the PLL clkin.
REQ-006 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: single-cycle request to (re)tune and relock.
REQ-008 SHALL have ports icp_req [5:0], lpfres_req [2:0], lpfcap_req [1:0], inputs: requested charge-pump and loop-filter settings.
REQ-009 SHALL have port pll_lock, input, 1: raw PLL lock, asynchronous to clk.
REQ-010 SHALL have port pll_reset, output, 1: active-high PLL reset.
REQ-011 SHALL have ports icpsel [5:0], lpfres [2:0], lpfcap [1:0], outputs: registered values to the PLL dynamic ICP/LPF inputs.
REQ-012 SHALL have ports busy, locked and fail, outputs, 1 each, plus attempts [3:0], output: current attempt index.

Function
REQ-013 SHALL pass pll_lock through a 2-flop synchronizer; "lock" below means the synchronized signal (2-cycle latency).
REQ-014 SHALL implement states IDLE, RESET, WAIT_LOCK, STABLE, LOCKED, FAIL.
REQ-015 SHALL accept start only in IDLE, LOCKED or FAIL, and ignore it in every other state.
REQ-016 On an accepted start, SHALL capture the *_req inputs into icpsel/lpfres/lpfcap in the same edge, clear attempts, clear locked and fail, set busy, and enter RESET.
REQ-017 SHALL change icpsel/lpfres/lpfcap only on an accepted start, holding them constant through RESET/WAIT_LOCK/STABLE.
REQ-018 In RESET, SHALL drive pll_reset=1 for exactly RST_CYCLES cycles, then enter WAIT_LOCK with pll_reset=0 and the timeout counter cleared.
REQ-019 In WAIT_LOCK: lock=1 SHALL enter STABLE with the stable counter cleared; when the timeout counter reaches LOCK_TIMEOUT-1 it SHALL either enter FAIL if attempts==MAX_RETRY-1, or increment attempts and re-enter RESET.
REQ-020 In STABLE, SHALL keep the timeout counter running; lock=0 SHALL return to WAIT_LOCK with the stable counter cleared, and a timeout SHALL act as in WAIT_LOCK.
REQ-021 When the stable counter reaches LOCK_STABLE-1 with lock=1, SHALL enter LOCKED, set locked=1 and clear busy.
REQ-022 In FAIL, SHALL hold pll_reset=1, fail=1 and busy=0.
REQ-023 If timeout and lock=1 coincide, lock SHALL take priority.
REQ-024 SHALL size counters as $clog2(parameter+1); attempts SHALL saturate at 15.

Reset
REQ-025 While rst_n=0, SHALL set: state=IDLE, pll_reset=1, icpsel=DEF_ICP, lpfres=DEF_RES, lpfcap=DEF_CAP, busy=0, locked=0, fail=0, attempts=0, all counters and synchronizer flops 0.
REQ-026 In IDLE, SHALL hold pll_reset=1 until the first accepted start.
REQ-027 An rst_n assertion mid-sequence SHALL abort the sequence and restore the REQ-025 values on the next edge.

Configuration
REQ-028 With PLL_DYN_CTRL_AUTO_RELOCK_EN defined, lock=0 in LOCKED SHALL clear locked, set busy, clear attempts and enter RESET, keeping the current settings.
REQ-029 Without PLL_DYN_CTRL_AUTO_RELOCK_EN, lock=0 in LOCKED SHALL clear locked and enter FAIL.

Structure
REQ-030 Package pll_dyn_pkg SHALL hold the state enum and the constants DEF_ICP, DEF_RES, DEF_CAP, plus the setting-field widths (6/3/2).
REQ-031 The synchronizer SHALL be a sub-module named sync_2ff; the FSM and counters SHALL live in pll_dyn_ctrl.

Verification (bench params RST_CYCLES=4, LOCK_TIMEOUT=100, LOCK_STABLE=8, MAX_RETRY=3)
REQ-032 Nominal: start with icp_req=6'h15, lpfres_req=3, lpfcap_req=1, pll_lock rising 20 cycles after pll_reset falls -> pll_reset high exactly 4 cycles, icpsel=6'h15, locked=1 exactly 2+8 cycles after the pll_lock rise, attempts=0.
REQ-033 Retry then success: pll_lock held 0 for the first attempt, raised on the second -> one reset pulse per attempt, attempts=1, locked=1.
REQ-034 Exhaustion: pll_lock held 0 -> 3 reset pulses, then FAIL with fail=1, pll_reset=1, attempts=2, busy=0.
REQ-035 Glitch: pll_lock high 5 cycles, low 1 cycle, then high -> stable count restarts, locked set only after 8 consecutive synchronized-high cycles.
REQ-036 Start while busy changes neither the outputs nor the state; a lock drop in LOCKED -> relock sequence (macro defined) or FAIL (macro undefined).
REQ-037 rst_n=0 asserted during WAIT_LOCK -> all outputs equal the REQ-025 values on the next edge.
